e_mult_div_unit: RTL and testbench

- Execute-stage multiply/divide unit; owns the HI/LO architectural registers.
- Implements mult, multu, div, divu, mthi, mtlo, mfhi and mflo with fixed multi-cycle latency.
- Exports busy for the hazard unit.
- Its md_o read value feeds the execute-stage MD result mux, which the E/M pipeline register captures.

---
 rtl/e_mult_div_unit.sv | 190 +++++++++++++++++++
 tb/tb_e_mult_div_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// busy window and writes the result to HI/LO on the last edge of that window.
module e_mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_o
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Latched operation kind: md_op - 1 for the four long-latency ops.
    typedef enum logic [1:0] {
        K_MULT  = 2'd0,
        K_MULTU = 2'd1,
        K_DIV   = 2'd2,
        K_DIVU  = 2'd3
    } kind_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    kind_t              kind_q, kind_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;

    logic               is_long_op;
    logic               launch;
    logic               done;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        div_n;
    logic [31:0]        div_d;
    logic [31:0]        uquo;
    logic [31:0]        urem;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [63:0]        result;
    logic               result_wr;

    assign is_long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                        (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign launch     = start && (state_q == S_IDLE) && is_long_op;
    assign done       = (state_q == S_RUN) && (cnt_q == CNT_W'(1));

    // All arithmetic works on the operands latched at launch, never live rs/rt.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide goes through one unsigned divider on magnitudes; the
    // 0x80000000 / -1 overflow case falls out as quo=0x80000000, rem=0.
    assign div_signed = (kind_q == K_DIV);
    assign a_neg      = div_signed && a_q[31];
    assign b_neg      = div_signed && b_q[31];
    assign div_n      = a_neg ? (32'd0 - a_q) : a_q;
    assign div_d      = b_neg ? (32'd0 - b_q) : b_q;
    assign uquo       = (div_d == 32'd0) ? 32'd0 : (div_n / div_d);
    assign urem       = (div_d == 32'd0) ? 32'd0 : (div_n % div_d);
    assign quo        = (a_neg ^ b_neg) ? (32'd0 - uquo) : uquo;
    assign rem        = a_neg ? (32'd0 - urem) : urem;

    always_comb begin
        result = {rem, quo};
        case (kind_q)
            K_MULT:  result = prod_s;
            K_MULTU: result = prod_u;
            default: result = {rem, quo};
        endcase
    end

    // Divide by zero leaves HI/LO untouched but still burns the full window.
    assign result_wr = !(kind_q[1] && (b_q == 32'd0));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN:   if (done)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    a_d    = rs;
                    b_d    = rt;
                    kind_d = kind_t'(md_op[1:0] - 2'd1);
                    cnt_d  = (md_op == OP_MULT || md_op == OP_MULTU) ?
                             CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (start && md_op == OP_MTHI) begin
                    hi_d = rs;
                end else if (start && md_op == OP_MTLO) begin
                    lo_d = rs;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (done && result_wr) begin
                    hi_d = result[63:32];
                    lo_d = result[31:0];
                end
            end
            default: cnt_d = '0;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            kind_q <= K_MULT;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
        end
    end

    // Read port: reflects registered HI/LO only, no bypass of a same-cycle mthi/mtlo.
    always_comb begin
        md_o = 32'd0;
        case (md_op)
            OP_MFHI: md_o = hi_q;
            OP_MFLO: md_o = lo_q;
            default: md_o = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Self-checking bench for e_mult_div_unit: directed cases plus randomized
// mult/div traffic checked against an arithmetic reference model.
module tb_e_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_o;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model of HI/LO and the pending-result scoreboard.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] exp_q[$];

    e_mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .md_o  (md_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
        longint      ps;
        logic [63:0] pu;
        int          ai, bi, q, r;
        logic [31:0] uq, ur;
        ref_result = {cur_hi, cur_lo};
        case (op)
            4'd1: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                ref_result = ps;
            end
            4'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                ref_result = pu;
            end
            4'd3: begin
                if (b == 32'd0) ref_result = {cur_hi, cur_lo};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = {32'd0, 32'h8000_0000};
                else begin
                    ai = int'(a);
                    bi = int'(b);
                    q = ai / bi;
                    r = ai % bi;
                    ref_result = {r, q};
                end
            end
            4'd4: begin
                if (b == 32'd0) ref_result = {cur_hi, cur_lo};
                else begin
                    uq = a / b;
                    ur = a % b;
                    ref_result = {ur, uq};
                end
            end
            default: ref_result = {cur_hi, cur_lo};
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs = 32'd0; rt = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    // Launch a long op; optionally scramble rs/rt during RUN and inject a
    // mthi that must be ignored. at_neg=1 means the caller is already at a negedge.
    task automatic issue_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit scramble, input bit inject, input bit at_neg);
        int          n;
        logic [63:0] e;
        if (!at_neg) @(negedge clk);
        start = 1'b1; md_op = op; rs = a; rt = b;
        exp_q.push_back(ref_result(op, a, b, m_hi, m_lo));
        n = (op <= 4'd2) ? MC : DC;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = 1'b0; md_op = 4'd0;
            if (scramble) begin rs = $urandom; rt = $urandom; end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_run op=%0d k=%0d: got %b want 1", op, k, busy);
            end
            n_cmp++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                n_err++;
                $display("FAIL hold_run op=%0d k=%0d: got %h_%h want %h_%h", op, k, hi, lo, m_hi, m_lo);
            end
            if (inject && k == 2) begin start = 1'b1; md_op = 4'd5; rs = 32'h0000_DEAD; end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        e = exp_q.pop_front();
        m_hi = e[63:32];
        m_lo = e[31:0];
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_done op=%0d: got %b want 0", op, busy);
        end
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_err++;
            $display("FAIL result op=%0d a=%h b=%h: got %h_%h want %h_%h", op, a, b, hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; md_op = op; rs = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        if (op == 4'd5) m_hi = v; else m_lo = v;
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            n_err++;
            $display("FAIL mt op=%0d: got busy=%b %h_%h want busy=0 %h_%h", op, busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        do_reset();
        md_op = 4'd7;
        #1;
        n_cmp++;
        if ({busy, hi, lo, md_o} !== {1'b0, 32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h md_o=%h want all 0", busy, hi, lo, md_o);
        end
        md_op = 4'd0;
    endtask

    task automatic test_reset_mid_div();
        do_mt(4'd5, 32'h55);
        do_mt(4'd6, 32'h66);
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; rs = 32'd100; rt = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_mid_div: got busy=%b %h_%h want 0 0_0", busy, hi, lo);
        end
        repeat (DC + 2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_discard: got busy=%b %h_%h want 0 0_0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        issue_md(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin
            n_err++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi, lo);
        end
        issue_md(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'h0000_0001, 32'hFFFF_FFFE}) begin
            n_err++;
            $display("FAIL multu_latch: got %h_%h want 00000001_fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        issue_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_err++;
            $display("FAIL div_signs: got %h_%h want ffffffff_fffffffd", hi, lo);
        end
        issue_md(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'h0000_0001, 32'h7FFF_FFFC}) begin
            n_err++;
            $display("FAIL divu: got %h_%h want 00000001_7ffffffc", hi, lo);
        end
    endtask

    task automatic test_div_corner();
        do_mt(4'd5, 32'h11);
        do_mt(4'd6, 32'h22);
        issue_md(4'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'h11, 32'h22}) begin
            n_err++;
            $display("FAIL div_by_zero: got %h_%h want 00000011_00000022", hi, lo);
        end
        issue_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin
            n_err++;
            $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi, lo);
        end
    endtask

    task automatic test_ignore_and_reads();
        issue_md(4'd1, 32'd1000, 32'd7, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'd7000) begin
            n_err++;
            $display("FAIL ignore_busy: got %h_%h want 00000000_00001b58", hi, lo);
        end
        do_mt(4'd5, 32'hCAFE_0001);
        // mfhi with start=1 must not change state; md_o tracks md_op combinationally.
        @(negedge clk);
        start = 1'b1; md_op = 4'd7;
        #1;
        n_cmp++;
        if (md_o !== m_hi) begin
            n_err++;
            $display("FAIL mfhi: got %h want %h", md_o, m_hi);
        end
        md_op = 4'd8; start = 1'b0;
        #1;
        n_cmp++;
        if (md_o !== m_lo) begin
            n_err++;
            $display("FAIL mflo: got %h want %h", md_o, m_lo);
        end
        md_op = 4'd0;
        #1;
        n_cmp++;
        if (md_o !== 32'd0) begin
            n_err++;
            $display("FAIL md_none: got %h want 0", md_o);
        end
        start = 1'b1; md_op = 4'd12; rs = 32'hFFFF_0000; rt = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = 4'd0;
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            n_err++;
            $display("FAIL reserved_op: got busy=%b %h_%h want busy=0 %h_%h", busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        issue_md(4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        issue_md(4'd3, 32'd17, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1);
        issue_md(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] corners[6];
        logic [3:0]  op;
        logic [31:0] a, b;
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9};
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = corners[$urandom_range(0, 5)];
                2:       b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            issue_md(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) do_mt(4'($urandom_range(5, 6)), $urandom);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs = 32'd0; rt = 32'd0;
        test_reset();
        test_reset_mid_div();
        test_mult();
        test_div();
        test_div_corner();
        test_ignore_and_reads();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
